// File: rtl/bus_sram_responder_if.sv
// System-bus signal bundle shared by the JTAG DMA initiator (master) and
// its responders (slave). Responder outputs are OR-combined on the bus, so
// every responder drives zeros whenever it is not actively responding.
interface bus_sram_responder_if;
  // initiator -> responder
  logic [31:0] address_dataIN;
  logic [3:0]  byte_enableIN;
  logic [7:0]  burst_sizeIN;
  logic        read_n_writeIN;
  logic        begin_transactionIN;
  logic        end_transactionIN;
  logic        data_validIN;
  logic        busyIN;
  // responder -> initiator
  logic [31:0] address_dataOUT;
  logic        end_transactionOUT;
  logic        data_validOUT;
  logic        busyOUT;
  logic        errorOUT;

  modport master (
    output address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
           begin_transactionIN, end_transactionIN, data_validIN, busyIN,
    input  address_dataOUT, end_transactionOUT, data_validOUT, busyOUT, errorOUT
  );

  modport slave (
    input  address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
           begin_transactionIN, end_transactionIN, data_validIN, busyIN,
    output address_dataOUT, end_transactionOUT, data_validOUT, busyOUT, errorOUT
  );
endinterface

// File: rtl/bus_sram_responder.sv
// Bus responder serving single/burst reads and writes from a local
// word-organised SRAM mapped at BASE_ADDRESS. Bursts that would run past the
// top of the window, or misaligned start addresses, get a one-cycle error
// response. Reads have one cycle of latency and then stream one word per
// cycle, prefetching the next word so back-to-back acceptance has no bubble.
module bus_sram_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int          ADDR_WIDTH   = 9
) (
  input logic                 system_clock,
  input logic                 system_reset,
  bus_sram_responder_if.slave bus
);

  localparam int WORDS = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LAT,
    S_READ,
    S_RD_END,
    S_WRITE,
    S_ERR
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [8:0]            r_cnt;        // words still to transfer
  logic [3:0]            r_be;
  logic [31:0]           r_mem [WORDS];
  logic [31:0]           r_rdata;

  logic [ADDR_WIDTH-1:0] w_begin_waddr;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [ADDR_WIDTH:0]   w_burst_top;
  logic                  w_select;
  logic                  w_error;
  logic                  w_accept;
  logic                  w_last_word;
  logic                  w_wr_fire;

  assign w_begin_waddr = bus.address_dataIN[ADDR_WIDTH+1:2];
  assign w_select      = bus.begin_transactionIN &&
                         (bus.address_dataIN[31:ADDR_WIDTH+2] == BASE_ADDRESS[31:ADDR_WIDTH+2]);
  // Last word index of the burst, one bit wider so running off the top is visible.
  assign w_burst_top   = {1'b0, w_begin_waddr} + (ADDR_WIDTH+1)'(bus.burst_sizeIN);
  assign w_error       = (bus.address_dataIN[1:0] != 2'b00) ||
                         (w_burst_top > (ADDR_WIDTH+1)'(WORDS - 1));
  assign w_accept      = (r_state == S_READ) && !bus.busyIN;
  assign w_last_word   = (r_cnt == 9'd1);
  // Writes are suppressed while reset is asserted so an abort never leaves a stray word.
  assign w_wr_fire     = system_reset && (r_state == S_WRITE) && bus.data_validIN &&
                         (r_cnt != 9'd0);
  // Look one word ahead on acceptance; otherwise re-read the word being presented.
  assign w_rd_addr     = w_accept ? r_waddr + ADDR_WIDTH'(1) : r_waddr;

  // State register.
  always_ff @(posedge system_clock) begin
    if (!system_reset) r_state <= S_IDLE;
    else               r_state <= w_next_state;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_select) begin
          if (w_error)                 w_next_state = S_ERR;
          else if (bus.read_n_writeIN) w_next_state = S_RD_LAT;
          else                         w_next_state = S_WRITE;
        end
      end
      S_RD_LAT: w_next_state = bus.end_transactionIN ? S_IDLE : S_READ;
      S_READ: begin
        if (bus.end_transactionIN)         w_next_state = S_IDLE;
        else if (w_accept && w_last_word)  w_next_state = S_RD_END;
      end
      S_RD_END: w_next_state = S_IDLE;
      S_WRITE:  if (bus.end_transactionIN) w_next_state = S_IDLE;
      S_ERR:    w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Transaction context: latched at begin, stepped per transferred word.
  always_ff @(posedge system_clock) begin
    if (!system_reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      r_waddr <= '0;
      r_cnt   <= '0;
      r_be    <= '0;
    end else if (r_state == S_IDLE && w_select) begin
      r_waddr <= w_begin_waddr;
      r_cnt   <= {1'b0, bus.burst_sizeIN} + 9'd1;
      r_be    <= bus.byte_enableIN;
    end else if (w_accept || w_wr_fire) begin
      r_waddr <= r_waddr + ADDR_WIDTH'(1);
      r_cnt   <= r_cnt - 9'd1;
    end
  end

  // SRAM: byte-lane writes and a registered read port.
  // NOTE: the array has no reset; contents survive reset and start undefined.
  always_ff @(posedge system_clock) begin
    if (w_wr_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) r_mem[r_waddr][8*b +: 8] <= bus.address_dataIN[8*b +: 8];
      end
    end
    r_rdata <= r_mem[w_rd_addr];
  end

  // Output decode: zero unless this responder is driving the bus.
  always_comb begin
    bus.address_dataOUT    = '0;
    bus.data_validOUT      = 1'b0;
    bus.end_transactionOUT = 1'b0;
    bus.busyOUT            = 1'b0;
    bus.errorOUT           = 1'b0;
    case (r_state)
      S_RD_LAT: bus.busyOUT = 1'b1;
      S_READ: begin
        bus.address_dataOUT = r_rdata;
        bus.data_validOUT   = 1'b1;
      end
      S_RD_END: bus.end_transactionOUT = 1'b1;
      S_ERR: begin
        bus.errorOUT           = 1'b1;
        bus.end_transactionOUT = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_sram_responder.sv
// Self-checking bench for bus_sram_responder: a table of directed
// transactions, hand-written abort/reset sequences, then random traffic,
// all checked cycle by cycle against a transaction-level memory model.
module tb_bus_sram_responder;

  localparam logic [31:0] BASE  = 32'h5000_0000;
  localparam int          AW    = 9;
  localparam int          WORDS = 2 ** AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_sram_responder_if bus ();

  bus_sram_responder #(
    .BASE_ADDRESS(BASE),
    .ADDR_WIDTH  (AW)
  ) dut (
    .system_clock(clk),
    .system_reset(rst_n),
    .bus         (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mem_m [WORDS];

  typedef struct {
    bit          rnw;
    logic [31:0] addr;
    int          burst;
    logic [3:0]  be;
    logic [31:0] data0;
    int          extra;
    logic [31:0] busy_mask;
    logic [35:0] exp_resp;   // {err,end,dv,busy,data} one cycle after begin
    logic [31:0] exp_word0;  // first read word (reads that succeed)
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (err,end,dv,busy,data)", name, act, exp);
    end
  endtask

  function automatic logic [35:0] outs();
    return {bus.errorOUT, bus.end_transactionOUT, bus.data_validOUT, bus.busyOUT,
            bus.address_dataOUT};
  endfunction

  function automatic logic [35:0] ex(bit e, bit en, bit dv, bit b, logic [31:0] d);
    return {e, en, dv, b, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Window / error rules in plain byte-offset arithmetic.
  function automatic bit in_window(logic [31:0] addr);
    int unsigned off = addr - BASE;
    return off < 4 * WORDS;
  endfunction

  function automatic bit is_err(logic [31:0] addr, int burst);
    int unsigned off = addr - BASE;
    return (off % 4 != 0) || (off / 4 + burst > WORDS - 1);
  endfunction

  task automatic do_read(input string tag, input logic [31:0] addr, input int burst,
                         input logic [31:0] mask, output logic [35:0] resp,
                         output logic [31:0] word0);
    int unsigned wa;
    int          i;
    int          k;
    bit          b;
    wa    = (addr - BASE) / 4;
    word0 = '0;
    bus.address_dataIN      = addr;
    bus.burst_sizeIN        = 8'(burst);
    bus.read_n_writeIN      = 1'b1;
    bus.begin_transactionIN = 1'b1;
    tick();
    bus.begin_transactionIN = 1'b0;
    bus.address_dataIN      = '0;
    resp = outs();
    if (!in_window(addr)) begin
      for (int c = 0; c < 3; c++) begin
        check({tag, "/unsel"}, outs(), '0);
        tick();
      end
      return;
    end
    if (is_err(addr, burst)) begin
      check({tag, "/err"}, outs(), ex(1, 1, 0, 0, '0));
      tick();
      check({tag, "/err_done"}, outs(), '0);
      return;
    end
    check({tag, "/lat"}, outs(), ex(0, 0, 0, 1, '0));
    tick();
    i = 0;
    k = 0;
    while (i <= burst) begin
      check({tag, "/word"}, outs(), ex(0, 0, 1, 0, mem_m[wa + i]));
      if (k == 0) word0 = bus.address_dataOUT;
      b = (k < 32) ? mask[k] : 1'b0;
      bus.busyIN = b;
      k++;
      if (!b) i++;
      tick();
    end
    bus.busyIN = 1'b0;
    check({tag, "/rd_end"}, outs(), ex(0, 1, 0, 0, '0));
    tick();
    check({tag, "/rd_idle"}, outs(), '0);
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input int burst,
                          input logic [3:0] be, input logic [31:0] data0, input int extra,
                          input bit gaps, input bit end_last, output logic [35:0] resp);
    int unsigned wa;
    int          n;
    logic [31:0] d;
    bit          sel;
    wa  = (addr - BASE) / 4;
    sel = in_window(addr);
    bus.address_dataIN      = addr;
    bus.burst_sizeIN        = 8'(burst);
    bus.byte_enableIN       = be;
    bus.read_n_writeIN      = 1'b0;
    bus.begin_transactionIN = 1'b1;
    tick();
    bus.begin_transactionIN = 1'b0;
    resp = outs();
    if (sel && is_err(addr, burst)) begin
      bus.address_dataIN = '0;
      check({tag, "/err"}, outs(), ex(1, 1, 0, 0, '0));
      tick();
      check({tag, "/err_done"}, outs(), '0);
      return;
    end
    n = burst + 1 + extra;
    for (int j = 0; j < n; j++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.data_validIN   = 1'b0;
        bus.address_dataIN = $urandom;
        check({tag, "/gap"}, outs(), '0);
        tick();
      end
      d = data0 + j * 32'h11;
      bus.data_validIN      = 1'b1;
      bus.address_dataIN    = d;
      bus.end_transactionIN = end_last && (j == n - 1);
      check({tag, "/wbeat"}, outs(), '0);
      if (sel && j <= burst) begin
        for (int b = 0; b < 4; b++) if (be[b]) mem_m[wa + j][8*b +: 8] = d[8*b +: 8];
      end
      tick();
    end
    bus.data_validIN   = 1'b0;
    bus.address_dataIN = '0;
    if (!end_last) begin
      bus.end_transactionIN = 1'b1;
      check({tag, "/wend"}, outs(), '0);
      tick();
    end
    bus.end_transactionIN = 1'b0;
    check({tag, "/wdone"}, outs(), '0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] resp;
    logic [31:0] w0;
    string       tag;
    logic [31:0] addr;
    int          burst;

    // Directed table: {rnw, addr, burst, be, data0, extra, busy_mask, exp_resp, exp_word0}
    vecs[0]  = '{0, BASE + 32'h10,  3, 4'hF,    32'h11,        0, 32'h0, 36'h0,           32'h0};
    vecs[1]  = '{1, BASE + 32'h10,  3, 4'hF,    32'h0,         0, 32'h6, 36'h1_0000_0000, 32'h0000_0011};
    vecs[2]  = '{0, BASE + 32'h10,  0, 4'b0101, 32'hAABB_CCDD, 0, 32'h0, 36'h0,           32'h0};
    vecs[3]  = '{1, BASE + 32'h10,  0, 4'hF,    32'h0,         0, 32'h0, 36'h1_0000_0000, 32'h00BB_00DD};
    vecs[4]  = '{1, BASE + 32'h7FC, 1, 4'hF,    32'h0,         0, 32'h0, 36'hC_0000_0000, 32'h0};
    vecs[5]  = '{1, BASE + 32'h2,   0, 4'hF,    32'h0,         0, 32'h0, 36'hC_0000_0000, 32'h0};
    vecs[6]  = '{1, 32'h6000_0000,  0, 4'hF,    32'h0,         0, 32'h0, 36'h0,           32'h0};
    vecs[7]  = '{0, BASE + 32'h7FC, 0, 4'hF,    32'hDEAD_BEEF, 0, 32'h0, 36'h0,           32'h0};
    vecs[8]  = '{1, BASE + 32'h7FC, 0, 4'hF,    32'h0,         0, 32'h1, 36'h1_0000_0000, 32'hDEAD_BEEF};
    vecs[9]  = '{0, BASE + 32'h7F8, 2, 4'hF,    32'h5555_0000, 0, 32'h0, 36'hC_0000_0000, 32'h0};
    vecs[10] = '{0, BASE + 32'h100, 3, 4'hF,    32'h1000,      0, 32'h0, 36'h0,           32'h0};
    vecs[11] = '{0, BASE + 32'h100, 1, 4'hF,    32'h2000,      2, 32'h0, 36'h0,           32'h0};
    vecs[12] = '{1, BASE + 32'h100, 3, 4'hF,    32'h0,         0, 32'h5, 36'h1_0000_0000, 32'h0000_2000};
    vecs[13] = '{1, BASE + 32'h800, 0, 4'hF,    32'h0,         0, 32'h0, 36'h0,           32'h0};
    vecs[14] = '{1, 32'h4FFF_FFFC,  0, 4'hF,    32'h0,         0, 32'h0, 36'h0,           32'h0};
    vecs[15] = '{1, BASE + 32'h7F0, 3, 4'hF,    32'h0,         0, 32'h2, 36'h1_0000_0000, 32'h8000_10BC};
    vecs[16] = '{0, 32'h6000_0010,  1, 4'hF,    32'h7777_0000, 1, 32'h0, 36'h0,           32'h0};

    bus.address_dataIN      = '0;
    bus.byte_enableIN       = '0;
    bus.burst_sizeIN        = '0;
    bus.read_n_writeIN      = 1'b0;
    bus.begin_transactionIN = 1'b0;
    bus.end_transactionIN   = 1'b0;
    bus.data_validIN        = 1'b0;
    bus.busyIN              = 1'b0;

    // Power-on reset: outputs stay quiet.
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("por", outs(), '0);
    end
    rst_n = 1'b1;
    tick();

    // Known image: word j = j*0x11 in the low half, 0x8000_0000 + j*0x11 in the high half.
    do_write("fill_lo", BASE,          255, 4'hF, 32'h0,         0, 1'b0, 1'b1, resp);
    do_write("fill_hi", BASE + 32'h400, 255, 4'hF, 32'h8000_0000, 0, 1'b0, 1'b0, resp);

    foreach (vecs[n]) begin
      tag = $sformatf("vec%0d", n);
      if (vecs[n].rnw) begin
        do_read(tag, vecs[n].addr, vecs[n].burst, vecs[n].busy_mask, resp, w0);
        if (vecs[n].exp_resp[32]) check({tag, "/word0"}, {4'h0, w0}, {4'h0, vecs[n].exp_word0});
      end else begin
        do_write(tag, vecs[n].addr, vecs[n].burst, vecs[n].be, vecs[n].data0, vecs[n].extra,
                 1'b0, n[0], resp);
      end
      check({tag, "/resp"}, resp, vecs[n].exp_resp);
    end

    // Abort during READ, with a stray begin mid-burst that must be ignored.
    bus.address_dataIN = BASE + 32'h10;  bus.burst_sizeIN = 8'd3;
    bus.read_n_writeIN = 1'b1;           bus.begin_transactionIN = 1'b1;
    tick();
    bus.begin_transactionIN = 1'b0;
    check("ab_lat", outs(), ex(0, 0, 0, 1, '0));
    tick();
    check("ab_w0", outs(), ex(0, 0, 1, 0, mem_m[4]));
    bus.address_dataIN = BASE + 32'h20;  bus.read_n_writeIN = 1'b0;
    bus.begin_transactionIN = 1'b1;
    tick();
    bus.begin_transactionIN = 1'b0;      bus.address_dataIN = '0;
    check("ab_w1", outs(), ex(0, 0, 1, 0, mem_m[5]));
    bus.end_transactionIN = 1'b1;
    tick();
    bus.end_transactionIN = 1'b0;
    check("ab_out", outs(), '0);
    tick();
    check("ab_idle", outs(), '0);

    // Abort during the latency cycle.
    bus.address_dataIN = BASE + 32'h40;  bus.burst_sizeIN = 8'd2;
    bus.read_n_writeIN = 1'b1;           bus.begin_transactionIN = 1'b1;
    tick();
    bus.begin_transactionIN = 1'b0;
    check("ablat_lat", outs(), ex(0, 0, 0, 1, '0));
    bus.end_transactionIN = 1'b1;
    tick();
    bus.end_transactionIN = 1'b0;
    check("ablat_out", outs(), '0);
    tick();
    check("ablat_idle", outs(), '0);
    do_read("after_abort", BASE + 32'h40, 2, 32'h0, resp, w0);

    // Reset held three cycles mid-read, then a fresh read is serviced.
    bus.address_dataIN = BASE + 32'h10;  bus.burst_sizeIN = 8'd3;
    bus.read_n_writeIN = 1'b1;           bus.begin_transactionIN = 1'b1;
    tick();
    bus.begin_transactionIN = 1'b0;
    tick();
    check("rst_rd_w0", outs(), ex(0, 0, 1, 0, mem_m[4]));
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_rd", outs(), '0);
    end
    rst_n = 1'b1;
    do_read("after_rst_rd", BASE + 32'h10, 3, 32'h2, resp, w0);
    check("after_rst_rd/resp", resp, ex(0, 0, 0, 1, '0));

    // Reset mid-write: the two words already written are retained.
    bus.address_dataIN = BASE + 32'h200; bus.burst_sizeIN = 8'd3;
    bus.byte_enableIN  = 4'hF;           bus.read_n_writeIN = 1'b0;
    bus.begin_transactionIN = 1'b1;
    tick();
    bus.begin_transactionIN = 1'b0;
    for (int j = 0; j < 2; j++) begin
      bus.data_validIN   = 1'b1;
      bus.address_dataIN = 32'hC0DE_0000 + j;
      mem_m[128 + j]     = 32'hC0DE_0000 + j;
      tick();
    end
    bus.data_validIN = 1'b0;  bus.address_dataIN = '0;
    rst_n = 1'b0;
    tick();
    check("rst_wr", outs(), '0);
    rst_n = 1'b1;
    tick();
    check("rst_wr_idle", outs(), '0);
    do_read("after_rst_wr", BASE + 32'h200, 3, 32'h0, resp, w0);

    // Random traffic against the model.
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 9))
        0:       addr = BASE + $urandom_range(0, 2047);
        1:       addr = $urandom;
        default: addr = BASE + 4 * $urandom_range(0, WORDS - 1);
      endcase
      burst = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
      tag = $sformatf("rnd%0d", t);
      if ($urandom_range(0, 1) == 1)
        do_read(tag, addr, burst, $urandom, resp, w0);
      else
        do_write(tag, addr, burst, 4'($urandom), $urandom, $urandom_range(0, 2),
                 1'b1, 1'($urandom), resp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
